// File: rtl/jacobi_div_pkg.sv
// jacobi_div_pkg: status codes, FP constants, delay-line entry and operand screening
// shared by the Jacobi divide issue stage.
package jacobi_div_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_ZERO_DEN = 2'b01,
    ST_INVALID  = 2'b10,
    ST_OVERFLOW = 2'b11
  } status_t;

  localparam logic [7:0]  EXP_MAX       = 8'd255;
  localparam logic [7:0]  EXP_DBL_LIMIT = 8'd254;
  localparam logic [31:0] QNAN          = 32'h7FC0_0000;
  localparam logic [31:0] PINF          = 32'h7F80_0000;

  // The user tag travels in a parallel shift line sized by the top's TAG_W.
  typedef struct packed {
    logic        valid;
    logic        bypass;
    status_t     status;
    logic [31:0] result;
  } dl_ent_t;

  function automatic status_t classify(input logic [31:0] num, input logic [31:0] den);
    return (num[30:23] == EXP_MAX || den[30:23] == EXP_MAX) ? ST_INVALID :
           (den[30:23] == 8'd0)                             ? ST_ZERO_DEN :
           (den[30:23] == EXP_DBL_LIMIT)                    ? ST_OVERFLOW : ST_OK;
  endfunction

  function automatic logic [31:0] bypass_value(input status_t st, input logic sign);
    return (st == ST_INVALID)  ? QNAN :
           (st == ST_OVERFLOW) ? {sign, PINF[30:0]} : 32'h0;
  endfunction

endpackage

// File: rtl/jacobi_div_issue_if.sv
// jacobi_div_issue_if: operand input, divider-core and result output signals of the
// Jacobi divide issue stage; master drives operands/quotient/out_ready, slave is the stage.
interface jacobi_div_issue_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_num;
  logic [31:0]      in_den;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic [31:0]      div_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_status;

  modport master (
    output in_valid, in_num, in_den, in_tag, div_result, out_ready,
    input  in_ready, div_a, div_b, out_valid, out_result, out_tag, out_status
  );

  modport slave (
    input  in_valid, in_num, in_den, in_tag, div_result, out_ready,
    output in_ready, div_a, div_b, out_valid, out_result, out_tag, out_status
  );
endinterface

// File: rtl/jacobi_res_fifo.sv
// jacobi_res_fifo: synchronous FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module jacobi_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [W-1:0]           wdata,
  input  logic                   rd,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end

  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;

  assign rdata = mem[rp];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr && count == (AW+1)'(DEPTH)));

endmodule

// File: rtl/jacobi_div_issue.sv
// jacobi_div_issue: screens (num, den) pairs, issues num/(2*den) to a fixed-latency divider
// and returns results in order through a credit-limited buffer. Macro JACOBI_DIV_STATS_EN adds counters.
module jacobi_div_issue
  import jacobi_div_pkg::*;
#(
  parameter int DIV_LATENCY = 28,
  parameter int TAG_W       = 4,
  parameter int OBUF_DEPTH  = 4
) (
  input logic clk,
  input logic rst_n,
  jacobi_div_issue_if.slave bus
`ifdef JACOBI_DIV_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_zero,
  output logic [15:0] stat_bad
`endif
);
  localparam int OW = $clog2(OBUF_DEPTH) + 1;
  localparam int FW = 2 + TAG_W + 32;

  logic                              rdy, acc, pop;
  logic [OW-1:0]                     occ, occ_nxt, fcnt;
  status_t                           st;
  dl_ent_t                           ent, ex;
  dl_ent_t [DIV_LATENCY-1:0]         dl;
  logic    [DIV_LATENCY-1:0][TAG_W-1:0] tg;
  logic [FW-1:0]                     wdata, rdata;

  assign acc          = bus.in_valid && rdy;
  assign pop          = bus.out_valid && bus.out_ready;
  assign occ_nxt      = occ + OW'(acc) - OW'(pop);
  assign bus.in_ready = rdy;
  assign st           = classify(bus.in_num, bus.in_den);
  assign ent          = '{valid: acc, bypass: st != ST_OK, status: st,
                          result: bypass_value(st, bus.in_num[31] ^ bus.in_den[31])};

  // Credits cover in-flight plus buffered results; ready comes from a register only.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      occ       <= '0;
      rdy       <= 1'b0;
      bus.div_a <= '0;
      bus.div_b <= '0;
    end else begin
      occ <= occ_nxt;
      rdy <= occ_nxt < OW'(OBUF_DEPTH);
      if (acc && st == ST_OK) begin
        bus.div_a <= bus.in_num;
        bus.div_b <= {bus.in_den[31], bus.in_den[30:23] + 8'd1, bus.in_den[22:0]};
      end
    end

  // Bypassed entries ride the same line as real divides, so order is preserved.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dl <= '0;
      tg <= '0;
    end else begin
      dl <= {dl[DIV_LATENCY-2:0], ent};
      tg <= {tg[DIV_LATENCY-2:0], bus.in_tag};
    end

  assign ex    = dl[DIV_LATENCY-1];
  assign wdata = {ex.status, tg[DIV_LATENCY-1], ex.bypass ? ex.result : bus.div_result};

  jacobi_res_fifo #(.W(FW), .DEPTH(OBUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (ex.valid),
    .wdata (wdata),
    .rd    (pop),
    .rdata (rdata),
    .count (fcnt)
  );

  assign bus.out_valid = fcnt != '0;
  assign {bus.out_status, bus.out_tag, bus.out_result} = bus.out_valid ? rdata : '0;

`ifdef JACOBI_DIV_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_issued <= '0;
      stat_zero   <= '0;
      stat_bad    <= '0;
    end else if (acc) begin
      if (st == ST_OK && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
      if (st == ST_ZERO_DEN && stat_zero != 16'hFFFF) stat_zero <= stat_zero + 16'd1;
      if ((st == ST_INVALID || st == ST_OVERFLOW) && stat_bad != 16'hFFFF) stat_bad <= stat_bad + 16'd1;
    end
`endif

endmodule

// File: tb/tb_jacobi_div_issue.sv
// tb_jacobi_div_issue: random and directed stimulus against a reference model of the
// screening/doubling rules; a queue scoreboard checks every output handshake in order.
module tb_jacobi_div_issue;
  localparam int L  = 28;
  localparam int TW = 4;
  localparam int D  = 4;
  localparam int EW = 2 + TW + 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jacobi_div_issue_if #(.TAG_W(TW)) bus ();

`ifdef JACOBI_DIV_STATS_EN
  logic [15:0] stat_issued, stat_zero, stat_bad;
`endif

  jacobi_div_issue #(.DIV_LATENCY(L), .TAG_W(TW), .OBUF_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef JACOBI_DIV_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_zero   (stat_zero),
    .stat_bad    (stat_bad)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [EW-1:0] q[$];
  int m_iss = 0, m_zero = 0, m_bad = 0;
  logic rmode = 1'b0;
  logic ready_req = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Stand-in divider: exact for powers of two, deterministic otherwise.
  function automatic logic [31:0] mdiv(input logic [31:0] a, input logic [31:0] b);
    return {a[31] ^ b[31], a[30:23] - b[30:23] + 8'd127, a[22:0] ^ b[22:0]};
  endfunction

  function automatic logic [EW-1:0] ref_out(input logic [31:0] n, input logic [31:0] d, input logic [TW-1:0] t);
    int en = int'(n[30:23]);
    int ed = int'(d[30:23]);
    logic s = n[31] ^ d[31];
    if (en == 255 || ed == 255) return {2'b10, t, 32'h7FC00000};
    if (ed == 0) return {2'b01, t, 32'h0};
    if (ed == 254) return {2'b11, t, s, 31'h7F800000};
    return {2'b00, t, mdiv(n, d + 32'h00800000)};
  endfunction

  function automatic logic [31:0] rnd_fp(input int cls);
    logic [31:0] v = $urandom;
    v[30:23] = (cls == 0) ? 8'h00 : (cls == 1) ? 8'hFF : (cls == 2) ? 8'hFE : 8'($urandom_range(1, 253));
    return v;
  endfunction

  // Divider core model: quotient of the operands registered at issue, DIV_LATENCY cycles later.
  logic [31:0] dpipe [L-1];
  always @(posedge clk) begin
    dpipe[0] <= mdiv(bus.div_a, bus.div_b);
    for (int i = 1; i < L - 1; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.div_result = dpipe[L-2];

  always @(posedge clk) begin
    #2;
    bus.out_ready = rmode ? 1'($urandom_range(0, 1)) : ready_req;
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      q.delete();
      m_iss = 0; m_zero = 0; m_bad = 0;
    end else if (bus.in_valid && bus.in_ready) begin
      e = ref_out(bus.in_num, bus.in_den, bus.in_tag);
      q.push_back(e);
      if (e[EW-1:EW-2] == 2'b00 && m_iss < 65535) m_iss++;
      if (e[EW-1:EW-2] == 2'b01 && m_zero < 65535) m_zero++;
      if (e[EW-1] && m_bad < 65535) m_bad++;
    end
  end

  logic [EW-1:0] prev;
  logic prev_hold = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    cur = {bus.out_status, bus.out_tag, bus.out_result};
    if (!rst_n) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", 64'(cur), 64'(prev));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: got %h with nothing expected", cur);
        end else chk("out", 64'(cur), 64'(q.pop_front()));
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev = cur;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] n, input logic [31:0] d, input logic [TW-1:0] t);
    int w = 0;
    bus.in_num = n; bus.in_den = d; bus.in_tag = t; bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 2000) begin step(1); w++; end
    if (!bus.in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for tag %0d", t);
      bus.in_valid = 1'b0;
      return;
    end
    step(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 5000) begin step(1); w++; end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic stale;
    bus.in_valid = 1'b0; bus.in_num = '0; bus.in_den = '0; bus.in_tag = '0;
    step(3);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_div_a", 64'(bus.div_a), 64'd0);
    chk("rst_div_b", 64'(bus.div_b), 64'd0);
    chk("rst_out", 64'({bus.out_status, bus.out_tag, bus.out_result}), 64'd0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    send(32'h40800000, 32'h3F800000, 4'h5);
    chk("t1_div_a", 64'(bus.div_a), 64'h40800000);
    chk("t1_div_b", 64'(bus.div_b), 64'h40000000);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin step(1); lat++; end
    chk("t1_latency", 64'(lat), 64'(L));
    chk("t1_first", 64'({bus.out_status, bus.out_tag, bus.out_result}), 64'({2'b00, 4'h5, 32'h40000000}));
    drain();

    send(32'h3F800000, 32'h00000000, 4'h1);
    send(32'h40000000, 32'h80000001, 4'h2);
    step(2);
    chk("t2_div_a_held", 64'(bus.div_a), 64'h40800000);
    chk("t2_div_b_held", 64'(bus.div_b), 64'h40000000);
    drain();

    send(32'h3F800000, 32'h7F800000, 4'h3);
    send(32'h40400000, 32'h3F800000, 4'h4);
    send(32'hBF800000, 32'h7F000000, 4'h5);
    drain();

    ready_req = 1'b0;
    step(1);
    for (int i = 0; i < D; i++) send(rnd_fp(3), rnd_fp(3), 4'(6 + i));
    chk("t4_full_ready", 64'(bus.in_ready), 64'd0);
    step(L + 2);
    chk("t4_still_blocked", 64'(bus.in_ready), 64'd0);
    chk("t4_out_valid", 64'(bus.out_valid), 64'd1);
    ready_req = 1'b1;
    step(1);
    ready_req = 1'b0;
    chk("t4_credit_back", 64'(bus.in_ready), 64'd1);
    ready_req = 1'b1;
    drain();

    ready_req = 1'b0;
    step(1);
    send(32'h40800000, 32'h40000000, 4'hA);
    step(L + 3);
    chk("t5_buffered", 64'(bus.out_valid), 64'd1);
    send(rnd_fp(3), rnd_fp(3), 4'hB);
    send(rnd_fp(3), rnd_fp(0), 4'hC);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t5_div_a", 64'(bus.div_a), 64'd0);
    chk("t5_div_b", 64'(bus.div_b), 64'd0);
    chk("t5_out", 64'({bus.out_status, bus.out_tag, bus.out_result}), 64'd0);
    step(2);
    rst_n = 1'b1;
    ready_req = 1'b1;
    stale = 1'b0;
    repeat (2 * L) begin step(1); if (bus.out_valid) stale = 1'b1; end
    chk("t5_no_stale", 64'(stale), 64'd0);

    rmode = 1'b1;
    for (int i = 0; i < 64; i++)
      send(rnd_fp(($urandom_range(0, 9) == 0) ? 1 : 3), rnd_fp($urandom_range(0, 7)), 4'(i));
    drain();
    rmode = 1'b0;
    step(2);

`ifdef JACOBI_DIV_STATS_EN
    chk("stat_issued", 64'(stat_issued), 64'(m_iss));
    chk("stat_zero", 64'(stat_zero), 64'(m_zero));
    chk("stat_bad", 64'(stat_bad), 64'(m_bad));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
